// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multicycle control unit: state encodings,
// supported opcodes, and the ALUOp / ALUSrcB select codes that drive the
// datapath.
// No ports (package).
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // The numeric values are visible on the state output, so they are pinned.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_IEXEC  = 4'd9
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles the controller spends waiting on memory and
// flags the cycle in which the MAX_WAIT-th wait happens. Only built when
// MULTICYCLE_CTRL_TIMEOUT_EN is defined.
// Ports:
//   clk      - clock
//   reset    - synchronous active-high reset, clears the count
//   clear    - clears the count on the next edge
//   count_en - this cycle is a wait cycle
//   expired  - this wait cycle is the MAX_WAIT-th consecutive one
// ---------------------------------------------------------------------------
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // r_count holds the number of wait cycles already completed, so the
    // current wait cycle is number r_count+1.
    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    logic [7:0] r_count;

    assign expired = count_en && (r_count == CNT_LAST);

    // Wait-cycle counter; cleared whenever the controller leaves the wait.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= 8'd0;
        end else if (count_en) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control unit for a multicycle RISC-V style datapath. A registered state
// machine steps each instruction through fetch, decode and its execution
// states; datapath controls are decoded from the current state.
// Optional feature: define MULTICYCLE_CTRL_TIMEOUT_EN to abort a memory
// access that waits MAX_WAIT cycles (mem_err pulse, return to FETCH).
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   opcode           - instruction opcode from IR
//   mem_ready        - memory completes the current access this cycle
//   RegWrite..PCSource, ALUOp, ALUSrcB - datapath controls
//   state            - current state encoding
//   illegal_op       - pulse: unsupported opcode seen in DECODE
//   mem_err          - pulse: memory access timed out
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned OPCODE_W = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                PCSource,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic                mem_err
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_badMaxWait
        $error("multicycle_ctrl: MAX_WAIT must be within 1..255");
    end

    state_t r_state;

    logic w_isRtype;
    logic w_isItype;
    logic w_isLoad;
    logic w_isStore;
    logic w_isBranch;
    logic w_opLegal;
    logic w_expired;

    assign w_isRtype  = (opcode == OPCODE_W'(OP_RTYPE));
    assign w_isItype  = (opcode == OPCODE_W'(OP_ITYPE));
    assign w_isLoad   = (opcode == OPCODE_W'(OP_LOAD));
    assign w_isStore  = (opcode == OPCODE_W'(OP_STORE));
    assign w_isBranch = (opcode == OPCODE_W'(OP_BRANCH));
    assign w_opLegal  = w_isRtype | w_isItype | w_isLoad | w_isStore | w_isBranch;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    logic w_waiting;
    logic w_timerClear;

    // Every non-waiting cycle ends in a state change, so "not waiting"
    // is exactly the clear condition; an expiry also restarts the count
    // because a FETCH timeout lands back in FETCH.
    assign w_waiting    = ((r_state == ST_FETCH) || (r_state == ST_MEMRD) ||
                           (r_state == ST_MEMWR)) && !mem_ready;
    assign w_timerClear = !w_waiting || w_expired;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_memWaitTimer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_timerClear),
        .count_en (w_waiting),
        .expired  (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // State register and transitions; unknown encodings fall back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else if (w_expired) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:  if (mem_ready) r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (w_isRtype)                  r_state <= ST_EXEC;
                    else if (w_isItype)             r_state <= ST_IEXEC;
                    else if (w_isLoad || w_isStore) r_state <= ST_MEMADR;
                    else if (w_isBranch)            r_state <= ST_BRANCH;
                    else                            r_state <= ST_FETCH;
                end
                ST_MEMADR: r_state <= w_isLoad ? ST_MEMRD : ST_MEMWR;
                ST_MEMRD:  if (mem_ready) r_state <= ST_MEMWB;
                ST_MEMWB:  r_state <= ST_FETCH;
                ST_MEMWR:  if (mem_ready) r_state <= ST_FETCH;
                ST_EXEC:   r_state <= ST_RWB;
                ST_IEXEC:  r_state <= ST_RWB;
                ST_RWB:    r_state <= ST_FETCH;
                ST_BRANCH: r_state <= ST_FETCH;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    // Control decode from the current state. Reset forces everything low
    // even though the register may still hold a mid-access state.
    always_comb begin
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        ALUOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_REG;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;
        if (!reset) begin
            mem_err = w_expired;
            case (r_state)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ALUOp   = ALUOP_ADD;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                ST_DECODE: begin
                    ALUSrcB    = SRCB_IMM;
                    ALUOp      = ALUOP_ADD;
                    illegal_op = !w_opLegal;
                end
                ST_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_ADD;
                end
                ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                ST_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                ST_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REG;
                    ALUOp   = ALUOP_FUNCT;
                end
                ST_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_IMM;
                end
                ST_RWB: begin
                    RegWrite = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SRCB_REG;
                    ALUOp       = ALUOP_BRANCH;
                    PCWriteCond = 1'b1;
                    PCSource    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state = reset ? 4'd0 : r_state;

endmodule
